// File: rtl/xor_chk_pkg.sv
// Shared types and helpers for the XOR frame checksum stage.
package xor_chk_pkg;

    localparam int DEFAULT_WIDTH     = 8;
    localparam int DEFAULT_MAX_WORDS = 256;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        HOLD
    } state_t;

    // Rotate left by one within the low w bits. The carrier is 64 bits wide, so w must be 2..63.
    function automatic logic [63:0] rotl1(input logic [63:0] v, input int unsigned w);
        logic [63:0] mask;
        mask  = (64'd1 << w) - 64'd1;
        rotl1 = ((v << 1) | (v >> (w - 1))) & mask;
    endfunction

endpackage

// File: rtl/xor_chk_ctrl.sv
// Frame controller: state machine, beat counter and termination decode.
module xor_chk_ctrl
    import xor_chk_pkg::*;
#(
    parameter int MAX_WORDS = DEFAULT_MAX_WORDS,
    parameter int CNT_W     = $clog2(DEFAULT_MAX_WORDS + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             beat_valid,
    input  logic             beat_last,
    output logic             beat_ready,
    output logic             accept,
    output logic             terminate,
    output logic             forced,
    output logic [CNT_W-1:0] cnt_n,
    output logic             res_valid,
    input  logic             res_ready
);

    state_t           state;
    state_t           state_n;
    logic [CNT_W-1:0] cnt;
    logic             hit_max;

    // Ready and result-valid decode straight from the state register, so there is no path from res_ready.
    assign beat_ready = (state != HOLD);
    assign res_valid  = (state == HOLD);

    assign accept    = beat_valid & beat_ready;
    assign cnt_n     = cnt + CNT_W'(1);
    assign hit_max   = (cnt_n == CNT_W'(MAX_WORDS));
    assign terminate = accept & (beat_last | hit_max);
    assign forced    = hit_max & ~beat_last;

    always_comb begin
        state_n = state;
        case (state)
            IDLE, ACCUM: begin
                if (accept) begin
                    state_n = terminate ? HOLD : ACCUM;
                end
            end
            HOLD: begin
                if (res_ready) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            if (terminate) begin
                cnt <= '0;
            end else if (accept) begin
                cnt <= cnt_n;
            end
        end
    end

endmodule

// File: rtl/xor_frame_checksum.sv
// Folds XOR-array beats into a per-frame checksum with beat count and overflow flag.
// Define CHECKSUM_ROTATE_EN to rotate the accumulator left by one before each fold.
module xor_frame_checksum
    import xor_chk_pkg::*;
#(
    parameter  int WIDTH     = DEFAULT_WIDTH,
    parameter  int MAX_WORDS = DEFAULT_MAX_WORDS,
    localparam int CNT_W     = $clog2(MAX_WORDS + 1)
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] I,
    input  logic             I_VALID,
    input  logic             I_LAST,
    output logic             I_READY,
    output logic [WIDTH-1:0] O,
    output logic [CNT_W-1:0] O_COUNT,
    output logic             O_ERR,
    output logic             O_VALID,
    input  logic             O_READY
);

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_f;
    logic [WIDTH-1:0] acc_n;
    logic             accept;
    logic             terminate;
    logic             forced;
    logic [CNT_W-1:0] cnt_n;

    xor_chk_ctrl #(
        .MAX_WORDS (MAX_WORDS),
        .CNT_W     (CNT_W)
    ) u_ctrl (
        .clk        (CLK),
        .reset      (RESET),
        .beat_valid (I_VALID),
        .beat_last  (I_LAST),
        .beat_ready (I_READY),
        .accept     (accept),
        .terminate  (terminate),
        .forced     (forced),
        .cnt_n      (cnt_n),
        .res_valid  (O_VALID),
        .res_ready  (O_READY)
    );

`ifdef CHECKSUM_ROTATE_EN
    assign acc_f = WIDTH'(rotl1(64'(acc), WIDTH));
`else
    assign acc_f = acc;
`endif

    assign acc_n = acc_f ^ I;

    // The terminating beat writes the result and clears the accumulator for the next frame.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            acc     <= '0;
            O       <= '0;
            O_COUNT <= '0;
            O_ERR   <= 1'b0;
        end else if (terminate) begin
            acc     <= '0;
            O       <= acc_n;
            O_COUNT <= cnt_n;
            O_ERR   <= forced;
        end else if (accept) begin
            acc     <= acc_n;
        end
    end

endmodule
